// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU slice: instruction width, NOP encoding and
// the state encoding of the instruction-memory loader FSM.
package cpu_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_COUNT = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    // States in which the loader is consuming the byte stream.
    function automatic logic st_accepts(input logic [2:0] s);
        return (s == ST_COUNT) || (s == ST_DATA) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: one synchronous write port, one combinational read port,
// whole array cleared by synchronous reset.
module imem_ram #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A same-cycle write is only visible after the edge, so reads see the old word.
    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction RAM plus the CPU fetch port.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = INST_W
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [7:0]    ByteIn,
    input  logic          ByteValid,
    output logic          ByteReady,
    input  logic [31:0]   Addr,
    output logic [DW-1:0] Inst,
    output logic          CpuHold,
    output logic          Done,
    output logic          Error,
    output logic [AW:0]   WordCount,
    output logic [2:0]    StateDbg
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [2:0]    state, state_nxt;
    logic [23:0]   stage;
    logic [1:0]    bcnt;
    logic [AW:0]   wptr;
    logic [AW:0]   wcount;
    logic          xfer, start_go, hdr_ok, word_end, word_last, ram_we;
    logic [DW-1:0] ram_rdata;
    logic          unused_addr;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    assign xfer      = ByteValid && ByteReady;
    assign start_go  = Start && !st_accepts(state);
    assign hdr_ok    = (ByteIn != 8'd0) && ({1'b0, ByteIn} <= 9'(DEPTH));
    assign word_end  = (bcnt == 2'd3);
    assign word_last = word_end && ((wptr + PTR_ONE) == wcount);
    assign ram_we    = (state == ST_DATA) && xfer && word_end;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (Start) state_nxt = ST_COUNT;
            end
            ST_COUNT: begin
                if (xfer) state_nxt = hdr_ok ? ST_DATA : ST_ERR;
            end
            ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (xfer && word_last) state_nxt = ST_CHECK;
`else
                if (xfer && word_last) state_nxt = ST_DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (xfer) state_nxt = (ByteIn == csum) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        ByteReady = st_accepts(state);
        CpuHold   = st_accepts(state) || (state == ST_ERR);
        Done      = (state == ST_DONE);
        Error     = (state == ST_ERR);
    end

    assign StateDbg  = state;
    assign WordCount = wcount;

    // Byte packing: three bytes are staged, the fourth completes the word.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stage  <= '0;
            bcnt   <= '0;
            wptr   <= '0;
            wcount <= '0;
        end else begin
            if (start_go) begin
                stage <= '0;
                bcnt  <= '0;
                wptr  <= '0;
            end
            if ((state == ST_COUNT) && xfer) begin
                wcount <= ByteIn[AW:0];
            end
            if ((state == ST_DATA) && xfer) begin
                if (word_end) begin
                    bcnt <= '0;
                    wptr <= wptr + PTR_ONE;
                end else begin
                    stage <= {stage[15:0], ByteIn};
                    bcnt  <= bcnt + 2'd1;
                end
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over data bytes only; the header is not included.
    always_ff @(posedge Clk) begin
        if (Reset || start_go) begin
            csum <= '0;
        end else if ((state == ST_DATA) && xfer) begin
            csum <= csum ^ ByteIn;
        end
    end
`endif

    imem_ram #(
        .AW(AW),
        .DW(DW)
    ) u_ram (
        .clk   (Clk),
        .reset (Reset),
        .we    (ram_we),
        .waddr (wptr[AW-1:0]),
        .wdata ({stage, ByteIn}),
        .raddr (Addr[AW+1:2]),
        .rdata (ram_rdata)
    );

    assign Inst = CpuHold ? NOP_INST : ram_rdata;

    assign unused_addr = ^{Addr[31:AW+2], Addr[1:0]};

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: random images checked against a
// word-array model built directly from the image bytes.
module tb_imem_loader;
  import cpu_pkg::*;

  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int SW    = 13;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [31:0] addr = 32'd0;
  logic [31:0] inst;
  logic        cpu_hold, done, error;
  logic [AW:0] word_count;
  logic [2:0]  state_dbg;

  imem_loader #(.AW(AW)) dut (
    .Clk       (clk),
    .Reset     (reset),
    .Start     (start),
    .ByteIn    (byte_in),
    .ByteValid (byte_valid),
    .ByteReady (byte_ready),
    .Addr      (addr),
    .Inst      (inst),
    .CpuHold   (cpu_hold),
    .Done      (done),
    .Error     (error),
    .WordCount (word_count),
    .StateDbg  (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [31:0]   inst_q[$];
  logic [SW-1:0] exp_q[$];
  logic          probe_inst = 1'b0;
  logic          probe_stat = 1'b0;
  logic [31:0]   e_inst;
  logic [SW-1:0] e_stat;
  logic [SW-1:0] a_stat;

  // reference model
  logic [31:0] ref_mem [DEPTH];
  logic [2:0]  m_state;
  logic [AW:0] m_wc;
  logic [7:0]  img[$];
  bit          gap_mode = 0;
  bit          check_hold = 0;

  always @(negedge clk) begin
    if (probe_inst) begin
      checks++;
      if (inst_q.size() == 0) begin
        errors++;
        $display("FAIL inst_underflow: no expected value queued");
      end else begin
        e_inst = inst_q.pop_front();
        if (inst !== e_inst) begin
          errors++;
          $display("FAIL fetch addr=%h: got %h expected %h", addr, inst, e_inst);
        end
      end
    end
    if (probe_stat) begin
      checks++;
      a_stat = {state_dbg, cpu_hold, done, error, byte_ready, word_count};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stat_underflow: no expected value queued");
      end else begin
        e_stat = exp_q.pop_front();
        if (a_stat !== e_stat) begin
          errors++;
          $display("FAIL status {state,hold,done,err,ready,wc}: got %h/%b%b%b%b/%0d expected %h/%b%b%b%b/%0d",
                   a_stat[12:10], a_stat[9], a_stat[8], a_stat[7], a_stat[6], a_stat[5:0],
                   e_stat[12:10], e_stat[9], e_stat[8], e_stat[7], e_stat[6], e_stat[5:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    m_state = ST_IDLE;
    m_wc    = '0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_status();
    logic hold;
    hold = (m_state == ST_ERR);
    exp_q.push_back({m_state, hold, m_state == ST_DONE, m_state == ST_ERR, 1'b0, m_wc});
    probe_stat = 1'b1;
    tick();
    probe_stat = 1'b0;
  endtask

  task automatic check_fetch_all();
    logic [31:0] a;
    probe_inst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      a = $urandom;
      a[AW+1:2] = i[AW-1:0];
      addr = a;
      inst_q.push_back((m_state == ST_ERR) ? NOP_INST : ref_mem[i]);
      tick();
    end
    probe_inst = 1'b0;
  endtask

  task automatic hold_probe();
    if (check_hold) begin
      addr = $urandom;
      inst_q.push_back(NOP_INST);
      probe_inst = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 50) begin
      hold_probe();
      tick();
      n++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout: got 0 expected 1 within 50 cycles");
      byte_valid = 1'b0;
      probe_inst = 1'b0;
      return;
    end
    hold_probe();
    tick();
    byte_valid = 1'b0;
    probe_inst = 1'b0;
    if (gap_mode) begin
      byte_in = 8'($urandom);
      tick();
    end
  endtask

  task automatic add_trailer(input bit good);
    logic [7:0] x = 8'd0;
    for (int k = 1; k < img.size(); k++) x ^= img[k];
    img.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
  endtask

  task automatic build_image(input int n, input bit good);
    img.delete();
    img.push_back(8'(n));
    for (int k = 0; k < 4 * n; k++) img.push_back(8'($urandom_range(0, 255)));
`ifdef IMEM_LOADER_CHECKSUM_EN
    add_trailer(good);
`else
    if (good) img.push_back(8'd0);
    img.pop_back();
`endif
  endtask

  task automatic run_image(input bit start_mid);
    int   n;
    logic [7:0] x;
    start_pulse();
    n = int'(img[0]);
    send_byte(img[0]);
    m_wc = img[0][AW:0];
    if (n == 0 || n > DEPTH) begin
      m_state = ST_ERR;
      return;
    end
    for (int k = 0; k < 4 * n; k++) begin
      if (start_mid && k == 5) start_pulse();
      send_byte(img[1 + k]);
    end
    for (int w = 0; w < n; w++)
      ref_mem[w] = {img[1 + 4*w], img[2 + 4*w], img[3 + 4*w], img[4 + 4*w]};
    m_state = ST_DONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
    x = 8'd0;
    for (int k = 1; k <= 4 * n; k++) x ^= img[k];
    send_byte(img[4*n + 1]);
    if (img[4*n + 1] != x) m_state = ST_ERR;
`else
    x = 8'd0;
`endif
  endtask

  task automatic junk_valid(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      byte_valid = 1'b1;
      byte_in    = 8'($urandom);
      tick();
    end
    byte_valid = 1'b0;
  endtask

  task automatic basic_image();
    img.delete();
    img = '{8'd2, 8'h20, 8'h21, 8'h00, 8'h0A, 8'h20, 8'h42, 8'h00, 8'h06};
`ifdef IMEM_LOADER_CHECKSUM_EN
    add_trailer(1'b1);
`endif
  endtask

  initial begin
    do_reset();
    do_reset();
    check_status();
    check_fetch_all();

    // valid bytes with no Start are ignored in IDLE
    junk_valid(3);
    check_status();

    // basic load
    basic_image();
    run_image(1'b0);
    check_status();
    addr = 32'h0000_0004;
    inst_q.push_back(32'h2042_0006);
    probe_inst = 1'b1;
    tick();
    probe_inst = 1'b0;
    check_fetch_all();

    // same image with gaps, hold checking and a stray Start mid-data
    junk_valid(3);
    check_status();
    gap_mode   = 1;
    check_hold = 1;
    basic_image();
    run_image(1'b1);
    gap_mode   = 0;
    check_status();
    check_fetch_all();

    // bad headers, each followed by a recovering load
    for (int t = 0; t < 3; t++) begin
      img.delete();
      img.push_back((t == 0) ? 8'd0 : (t == 1) ? 8'd33 : 8'($urandom_range(34, 255)));
      run_image(1'b0);
      check_status();
      check_fetch_all();
      build_image($urandom_range(1, DEPTH), 1'b1);
      run_image(1'b0);
      check_status();
      check_fetch_all();
    end

    // reset mid-load after five data bytes
    build_image(2, 1'b1);
    start_pulse();
    send_byte(img[0]);
    for (int k = 1; k <= 5; k++) send_byte(img[k]);
    do_reset();
    check_status();
    check_fetch_all();

    // random images
    for (int t = 0; t < 10; t++) begin
      build_image($urandom_range(1, DEPTH), $urandom_range(0, 3) != 0);
      gap_mode   = $urandom_range(0, 1) != 0;
      check_hold = $urandom_range(0, 1) != 0;
      run_image($urandom_range(0, 1) != 0);
      gap_mode = 0;
      check_status();
      check_fetch_all();
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // fixed checksum cases: trailer 0x33 matches, 0x34 does not
    img.delete();
    img = '{8'd1, 8'h00, 8'h43, 8'h50, 8'h20, 8'h33};
    run_image(1'b0);
    check_status();
    check_fetch_all();
    img.delete();
    img = '{8'd1, 8'h00, 8'h43, 8'h50, 8'h20, 8'h34};
    run_image(1'b0);
    check_status();
    check_fetch_all();
`endif

    tick();
    if (inst_q.size() != 0 || exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_expectations: got %0d/%0d expected 0/0", inst_q.size(), exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
